// File: rtl/kb_display_pkg.sv
// Shared digit-register type and seven-segment glyph table for the Kabeta display drivers.
// Glyphs are kept active-high here; polarity is applied at the output stage.
package kb_display_pkg;

    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
        logic       blank;
    } digit_t;

    localparam logic [7:0] SEG_OFF_ACTIVE_HIGH = 8'h00;

    localparam digit_t DIGIT_RESET = '{hex: 4'h0, dp: 1'b0, blank: 1'b1};

    // Bit 0..6 = segments a..g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-register to segment-line decoder, including decimal point, blanking
// and output polarity.
module seg7_decoder
    import kb_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  digit_t     digit_i,
    output logic [7:0] seg_o
);

    logic [7:0] seg_active_high;

    always_comb begin
        seg_active_high = SEG_OFF_ACTIVE_HIGH;
        if (!digit_i.blank) begin
            seg_active_high = {digit_i.dp, hex_to_seg(digit_i.hex)};
        end
        seg_o = SEG_ACTIVE_LOW ? ~seg_active_high : seg_active_high;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-digit registers, slot/sub-slot scan counters,
// brightness PWM with a guard sub-slot, and fully registered segment/digit outputs.
module seg_scan_driver
    import kb_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned SUB_CYCLES     = 6250,
    parameter int unsigned BRIGHT_BITS    = 3,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    localparam int unsigned AddrW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   WrEn,
    input  logic [AddrW-1:0]       WrAddr,
    input  logic [3:0]             WrHex,
    input  logic                   WrDp,
    input  logic                   WrBlank,
    input  logic [BRIGHT_BITS-1:0] Brightness,
    output logic [7:0]             Segment,
    output logic [NUM_DIGITS-1:0]  Digital,
    output logic                   ScanTick
);

    localparam int unsigned SubW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

    localparam logic [SubW-1:0]       SubLast  = SubW'(SUB_CYCLES - 1);
    localparam logic [AddrW-1:0]      DigLast  = AddrW'(NUM_DIGITS - 1);
    localparam logic [AddrW:0]        DigCount = (AddrW + 1)'(NUM_DIGITS);
    localparam logic [BRIGHT_BITS-1:0] SlotLast = {BRIGHT_BITS{1'b1}};

    localparam logic [7:0] SegOff =
        SEG_ACTIVE_LOW ? ~SEG_OFF_ACTIVE_HIGH : SEG_OFF_ACTIVE_HIGH;
    localparam logic [NUM_DIGITS-1:0] DigOff =
        DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Scan position.
    logic [SubW-1:0]        sub_q, sub_d;
    logic [BRIGHT_BITS-1:0] slot_q, slot_d;
    logic [AddrW-1:0]       dig_q, dig_d;

    logic [BRIGHT_BITS-1:0] bright_q, bright_d;

    digit_t regs_q [NUM_DIGITS];
    digit_t regs_d [NUM_DIGITS];

    logic [7:0]            segment_q, segment_d;
    logic [NUM_DIGITS-1:0] digital_q, digital_d;
    logic                  tick_q, tick_d;

    logic                  slot_start;
    logic                  lit;
    logic [7:0]            seg_pattern;
    logic [NUM_DIGITS-1:0] dig_onehot;

    // Scan counters: sub wraps into slot, slot wraps into digit.
    always_comb begin
        sub_d  = sub_q + 1'b1;
        slot_d = slot_q;
        dig_d  = dig_q;
        if (sub_q == SubLast) begin
            sub_d  = '0;
            slot_d = slot_q + 1'b1;
            if (slot_q == SlotLast) begin
                dig_d = (dig_q == DigLast) ? '0 : dig_q + 1'b1;
            end
        end
    end

    // Brightness is sampled only at slot start so a digit never sees a partial PWM window.
    always_comb begin
        slot_start = (slot_q == '0) && (sub_q == '0);
        bright_d   = slot_start ? Brightness : bright_q;
    end

    // Out-of-range addresses are dropped rather than aliased onto a real digit.
    always_comb begin
        regs_d = regs_q;
        if (WrEn && ({1'b0, WrAddr} < DigCount)) begin
            regs_d[WrAddr] = '{hex: WrHex, dp: WrDp, blank: WrBlank};
        end
    end

    seg7_decoder #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg7_decoder (
        .digit_i(regs_q[dig_q]),
        .seg_o  (seg_pattern)
    );

    // Sub-slot 0 is always dark to hide the segment-line transition between digits.
    always_comb begin
        lit = (slot_q != '0) && (slot_q <= bright_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_onehot[i] = (dig_q == AddrW'(i));
        end
        segment_d = SegOff;
        digital_d = DigOff;
        if (lit) begin
            segment_d = seg_pattern;
            digital_d = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
        end
        tick_d = (sub_q == '0) && (slot_q == '0) && (dig_q == '0);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sub_q     <= '0;
            slot_q    <= '0;
            dig_q     <= '0;
            bright_q  <= '0;
            segment_q <= SegOff;
            digital_q <= DigOff;
            tick_q    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs_q[i] <= DIGIT_RESET;
            end
        end else begin
            sub_q     <= sub_d;
            slot_q    <= slot_d;
            dig_q     <= dig_d;
            bright_q  <= bright_d;
            segment_q <= segment_d;
            digital_q <= digital_d;
            tick_q    <= tick_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign Segment  = segment_q;
    assign Digital  = digital_q;
    assign ScanTick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position reference model queues the expected
// outputs for every edge; scenario tasks pop and compare, plus targeted checks per scenario.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: 4 digits, 2-cycle sub-slots, 4 sub-slots, active-low.
    logic       rst_n, wr_en, wr_dp, wr_blank, scan_tick;
    logic [1:0] wr_addr, bright;
    logic [3:0] wr_hex, dig;
    logic [7:0] seg;

    seg_scan_driver #(
        .NUM_DIGITS(4), .SUB_CYCLES(2), .BRIGHT_BITS(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .Clock(clk), .Reset(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrHex(wr_hex),
        .WrDp(wr_dp), .WrBlank(wr_blank), .Brightness(bright),
        .Segment(seg), .Digital(dig), .ScanTick(scan_tick)
    );

    // Second DUT: 5 digits so addresses 5..7 exist on the port; active-high outputs.
    logic       rst5_n, wr5_en, wr5_dp, wr5_blank, tick5;
    logic [2:0] wr5_addr;
    logic [3:0] wr5_hex;
    logic [0:0] bright5;
    logic [7:0] seg5;
    logic [4:0] dig5;

    seg_scan_driver #(
        .NUM_DIGITS(5), .SUB_CYCLES(1), .BRIGHT_BITS(1),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut5 (
        .Clock(clk), .Reset(rst5_n), .WrEn(wr5_en), .WrAddr(wr5_addr), .WrHex(wr5_hex),
        .WrDp(wr5_dp), .WrBlank(wr5_blank), .Brightness(bright5),
        .Segment(seg5), .Digital(dig5), .ScanTick(tick5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model (main DUT) ----------------
    int          pos;
    logic [1:0]  bright_m;
    logic [5:0]  regs_m [4];   // {hex, dp, blank}
    logic [12:0] exp_q [$];    // {tick, segment, digital}

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        logic [6:0] r;
        case (h)
            4'h0: r = 7'h3F; 4'h1: r = 7'h06; 4'h2: r = 7'h5B; 4'h3: r = 7'h4F;
            4'h4: r = 7'h66; 4'h5: r = 7'h6D; 4'h6: r = 7'h7D; 4'h7: r = 7'h07;
            4'h8: r = 7'h7F; 4'h9: r = 7'h6F; 4'hA: r = 7'h77; 4'hB: r = 7'h7C;
            4'hC: r = 7'h39; 4'hD: r = 7'h5E; 4'hE: r = 7'h79; default: r = 7'h71;
        endcase
        return r;
    endfunction

    // Output that reflects frame position p (p = 0..31).
    function automatic logic [12:0] expect_out(input int p, input logic [1:0] b,
                                               input logic [5:0] r);
        int s, d;
        logic [7:0] sg;
        logic [3:0] dg;
        s  = (p / 2) % 4;
        d  = (p / 8) % 4;
        sg = 8'hFF;
        dg = 4'hF;
        if (s >= 1 && s <= int'(b)) begin
            dg[d] = 1'b0;
            if (!r[0]) sg = ~{r[1], seg_ref(r[5:2])};
        end
        return {(p == 0), sg, dg};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            pos      <= 0;
            bright_m <= 2'd0;
            for (int i = 0; i < 4; i++) regs_m[i] <= 6'b000001;
            exp_q.push_back({1'b0, 8'hFF, 4'hF});
        end else begin
            exp_q.push_back(expect_out(pos, bright_m, regs_m[(pos / 8) % 4]));
            if (pos % 8 == 0) bright_m <= bright;
            if (wr_en) regs_m[wr_addr] <= {wr_hex, wr_dp, wr_blank};
            pos <= (pos + 1) % 32;
        end
    end

    task automatic step(output logic [12:0] obs, output logic [12:0] want, output bit got);
        @(posedge clk);
        #1;
        obs  = {scan_tick, seg, dig};
        got  = (exp_q.size() > 0);
        want = got ? exp_q.pop_front() : 13'h0;
    endtask

    task automatic sync_frame(input string name);
        logic [12:0] obs, want;
        bit got, seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL %s_sync c%0d: got %h want %h", name, i, obs, want);
            end
            seen = obs[12];
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_sync: ScanTick got none within 40 cycles, want one", name);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        logic [12:0] obs, want;
        bit got;
        int first, ticks;
        rst_n = 1'b0; bright = 2'd3; wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL reset c%0d: got %h want %h", i, obs, want);
            end
        end
        rst_n = 1'b1;
        first = -1; ticks = 0;
        for (int i = 0; i < 70; i++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL idle c%0d: got %h want %h", i, obs, want);
            end
            if (obs[12]) begin
                ticks++;
                if (first < 0) first = i;
            end
            n_tests++;
            if (obs[11:4] !== 8'hFF) begin
                n_fail++;
                $display("FAIL idle_seg c%0d: got %h want ff", i, obs[11:4]);
            end
        end
        n_tests++;
        if (first !== 0 || ticks !== 3) begin
            n_fail++;
            $display("FAIL idle_tick: got first=%0d count=%0d want first=0 count=3", first, ticks);
        end
    endtask

    task automatic test_pattern;
        logic [12:0] obs, want;
        bit got;
        logic [3:0] hexes [4];
        logic [7:0] segs [4];
        int cnt [4];
        int guard;
        hexes[0] = 4'h1; hexes[1] = 4'h8; hexes[2] = 4'hA; hexes[3] = 4'hF;
        segs[0] = 8'hF9; segs[1] = 8'h00; segs[2] = 8'h88; segs[3] = 8'h8E;
        bright = 2'd3;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_hex = hexes[i]; wr_dp = (i == 1); wr_blank = 1'b0;
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL pattern_wr c%0d: got %h want %h", i, obs, want);
            end
        end
        wr_en = 1'b0;
        sync_frame("pattern");
        guard = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 32; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL pattern c%0d: got %h want %h", k, obs, want);
            end
            if (obs[3:0] === 4'hF) guard++;
            for (int i = 0; i < 4; i++) begin
                if (obs[3:0] === ~(4'b0001 << i)) begin
                    cnt[i]++;
                    n_tests++;
                    if (obs[11:4] !== segs[i]) begin
                        n_fail++;
                        $display("FAIL pattern_seg d%0d: got %h want %h", i, obs[11:4], segs[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cnt[i] !== 6) begin
                n_fail++;
                $display("FAIL pattern_lit d%0d: got %0d cycles want 6", i, cnt[i]);
            end
        end
        n_tests++;
        if (guard !== 8) begin
            n_fail++;
            $display("FAIL pattern_guard: got %0d dark cycles want 8", guard);
        end
    endtask

    task automatic test_brightness;
        logic [12:0] obs, want;
        bit got;
        int cnt [4];
        int dark;
        bright = 2'd1;
        sync_frame("bright1");
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 32; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL bright1 c%0d: got %h want %h", k, obs, want);
            end
            for (int i = 0; i < 4; i++) if (obs[3:0] === ~(4'b0001 << i)) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cnt[i] !== 2) begin
                n_fail++;
                $display("FAIL bright1_lit d%0d: got %0d cycles want 2", i, cnt[i]);
            end
        end
        bright = 2'd0;
        sync_frame("bright0");
        dark = 0;
        for (int k = 0; k < 32; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL bright0 c%0d: got %h want %h", k, obs, want);
            end
            if (obs[3:0] === 4'hF) dark++;
        end
        n_tests++;
        if (dark !== 32) begin
            n_fail++;
            $display("FAIL bright0_dark: got %0d dark cycles want 32", dark);
        end
    endtask

    task automatic test_mid_slot;
        logic [12:0] obs, want;
        bit got;
        int c0, c1;
        bright = 2'd3;
        sync_frame("midslot");
        c0 = 0; c1 = 0;
        for (int k = 1; k < 16; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL midslot c%0d: got %h want %h", k, obs, want);
            end
            if (obs[3:0] === 4'hE) c0++;
            if (obs[3:0] === 4'hD) c1++;
            if (k == 3) bright = 2'd1;
        end
        n_tests++;
        if (c0 !== 6 || c1 !== 2) begin
            n_fail++;
            $display("FAIL midslot_lit: got d0=%0d d1=%0d want d0=6 d1=2", c0, c1);
        end
    endtask

    task automatic test_write_lit;
        logic [12:0] obs, want;
        bit got;
        bright = 2'd3;
        sync_frame("wrlit");
        for (int k = 1; k < 24; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL wrlit c%0d: got %h want %h", k, obs, want);
            end
            if (k == 19) begin
                n_tests++;
                if (obs[11:0] !== {8'h88, 4'hB}) begin
                    n_fail++;
                    $display("FAIL wrlit_old: got %h want 88b", obs[11:0]);
                end
            end
            if (k == 20) begin
                n_tests++;
                if (obs[11:0] !== {8'hB0, 4'hB}) begin
                    n_fail++;
                    $display("FAIL wrlit_new: got %h want b0b", obs[11:0]);
                end
            end
            wr_en = (k == 18);
            wr_addr = 2'd2; wr_hex = 4'h3; wr_dp = 1'b0; wr_blank = 1'b0;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [12:0] obs, want;
        bit got;
        bright = 2'd3;
        sync_frame("rstmid");
        for (int k = 1; k < 13; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL rstmid c%0d: got %h want %h", k, obs, want);
            end
            if (k == 10) begin
                n_tests++;
                if (obs[3:0] !== 4'hD) begin
                    n_fail++;
                    $display("FAIL rstmid_lit: got dig %h want d", obs[3:0]);
                end
                rst_n = 1'b0;
            end
            if (k == 11) begin
                n_tests++;
                if (obs !== {1'b0, 8'hFF, 4'hF}) begin
                    n_fail++;
                    $display("FAIL rstmid_off: got %h want 0fff", obs);
                end
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want || obs[11:4] !== 8'hFF) begin
                n_fail++;
                $display("FAIL rstmid_blank c%0d: got %h want %h (seg ff)", k, obs, want);
            end
        end
    endtask

    task automatic test_addr_range;
        logic [12:0] obs, want;
        bit got;
        logic [7:0] pat [5];
        int lit_cnt, idx;
        bright5 = 1'b1;
        rst5_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr5_en = 1'b1; wr5_addr = 3'(i); wr5_blank = 1'b0;
            wr5_hex = (i < 5) ? 4'(i) : 4'h8;
            wr5_dp  = (i >= 5);
            if (i < 5) pat[i] = {1'b0, seg_ref(4'(i))};
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL range_main c%0d: got %h want %h", i, obs, want);
            end
        end
        wr5_en = 1'b0;
        lit_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(obs, want, got);
            n_tests++;
            if (!got || obs !== want) begin
                n_fail++;
                $display("FAIL range_main c%0d: got %h want %h", k + 8, obs, want);
            end
            n_tests++;
            if ($countones(dig5) == 1) begin
                lit_cnt++;
                idx = $clog2(int'(dig5));
                if (seg5 !== pat[idx]) begin
                    n_fail++;
                    $display("FAIL range_seg d%0d: got %h want %h", idx, seg5, pat[idx]);
                end
            end else if (dig5 !== 5'h00 || seg5 !== 8'h00) begin
                n_fail++;
                $display("FAIL range_dark c%0d: got dig %h seg %h want 00 00", k, dig5, seg5);
            end
        end
        n_tests++;
        if (lit_cnt !== 10) begin
            n_fail++;
            $display("FAIL range_lit: got %0d lit cycles want 10", lit_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_hex = 4'h0; wr_dp = 1'b0;
        wr_blank = 1'b0; bright = 2'd3;
        rst5_n = 1'b0; wr5_en = 1'b0; wr5_addr = 3'd0; wr5_hex = 4'h0; wr5_dp = 1'b0;
        wr5_blank = 1'b0; bright5 = 1'b0;
        test_reset();
        test_pattern();
        test_brightness();
        test_mid_slot();
        test_write_lit();
        test_reset_mid();
        test_addr_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got past 200000 time units, want earlier finish");
        $fatal(1, "timeout");
    end

endmodule
